// File: rtl/regbank_writeback.sv
// EV22 architectural register bank: 62 flop registers with a single-cycle ALU write
// port and a handshaked load port backed by a small in-order pending queue.

module regbank_cell #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge clk) begin
      if (reset)   q <= '0;
      else if (we) q <= d;
   end
endmodule

module regbank_writeback #(
   parameter int WIDTH  = 16,
   parameter int NREG   = 62,
   parameter int QDEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             alu_we,
   input  logic [5:0]       alu_addr,
   input  logic [WIDTH-1:0] alu_data,
   input  logic             ld_valid,
   output logic             ld_ready,
   input  logic [5:0]       ld_addr,
   input  logic [WIDTH-1:0] ld_data,
   output logic [1:0]       pend_cnt,
   output logic [WIDTH-1:0] R00,
   output logic [WIDTH-1:0] R01,
   output logic [WIDTH-1:0] R02,
   output logic [WIDTH-1:0] R03,
   output logic [WIDTH-1:0] R04,
   output logic [WIDTH-1:0] R05,
   output logic [WIDTH-1:0] R06,
   output logic [WIDTH-1:0] R07,
   output logic [WIDTH-1:0] R08,
   output logic [WIDTH-1:0] R09,
   output logic [WIDTH-1:0] R10,
   output logic [WIDTH-1:0] R11,
   output logic [WIDTH-1:0] R12,
   output logic [WIDTH-1:0] R13,
   output logic [WIDTH-1:0] R14,
   output logic [WIDTH-1:0] R15,
   output logic [WIDTH-1:0] R16,
   output logic [WIDTH-1:0] R17,
   output logic [WIDTH-1:0] R18,
   output logic [WIDTH-1:0] R19,
   output logic [WIDTH-1:0] R20,
   output logic [WIDTH-1:0] R21,
   output logic [WIDTH-1:0] R22,
   output logic [WIDTH-1:0] R23,
   output logic [WIDTH-1:0] R24,
   output logic [WIDTH-1:0] R25,
   output logic [WIDTH-1:0] R26,
   output logic [WIDTH-1:0] R27,
   output logic [WIDTH-1:0] R28,
   output logic [WIDTH-1:0] R29,
   output logic [WIDTH-1:0] R30,
   output logic [WIDTH-1:0] R31,
   output logic [WIDTH-1:0] R32,
   output logic [WIDTH-1:0] R33,
   output logic [WIDTH-1:0] R34,
   output logic [WIDTH-1:0] R35,
   output logic [WIDTH-1:0] R36,
   output logic [WIDTH-1:0] R37,
   output logic [WIDTH-1:0] R38,
   output logic [WIDTH-1:0] R39,
   output logic [WIDTH-1:0] R40,
   output logic [WIDTH-1:0] R41,
   output logic [WIDTH-1:0] R42,
   output logic [WIDTH-1:0] R43,
   output logic [WIDTH-1:0] R44,
   output logic [WIDTH-1:0] R45,
   output logic [WIDTH-1:0] R46,
   output logic [WIDTH-1:0] R47,
   output logic [WIDTH-1:0] R48,
   output logic [WIDTH-1:0] R49,
   output logic [WIDTH-1:0] R50,
   output logic [WIDTH-1:0] R51,
   output logic [WIDTH-1:0] R52,
   output logic [WIDTH-1:0] R53,
   output logic [WIDTH-1:0] R54,
   output logic [WIDTH-1:0] R55,
   output logic [WIDTH-1:0] R56,
   output logic [WIDTH-1:0] R57,
   output logic [WIDTH-1:0] R58,
   output logic [WIDTH-1:0] R59,
   output logic [WIDTH-1:0] R60,
   output logic [WIDTH-1:0] R61
);
   localparam int QW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = $clog2(QDEPTH + 1);

   typedef struct packed {
      logic [5:0]       addr;
      logic [WIDTH-1:0] data;
      logic             dead;
   } ent_t;

   ent_t                         q [QDEPTH];
   logic [QW-1:0]                hd, tl;
   logic [CW-1:0]                cnt;
   logic [NREG-1:0][WIDTH-1:0]   r;

   logic             full, empty, acc, alu_hit, pop, direct, enq;
   logic             wr_en;
   logic [5:0]       wr_addr;
   logic [WIDTH-1:0] wr_data;
   ent_t             head;

   function automatic logic live(input logic [5:0] a);
      return {1'b0, a} < 7'(NREG);
   endfunction

   function automatic logic [QW-1:0] nxt(input logic [QW-1:0] p);
      return (p == QW'(QDEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full     = (cnt == CW'(QDEPTH));
   assign empty    = (cnt == '0);
   assign ld_ready = ~reset & ~full;
   assign pend_cnt = 2'(cnt);
   assign acc      = ld_valid & ld_ready;
   assign alu_hit  = alu_we & live(alu_addr);
   assign head     = q[hd];

   // ALU owns the write slot; otherwise the oldest queued load, else a load that bypasses the empty queue.
   assign pop    = ~alu_we & ~empty;
   assign direct = ~alu_we & empty & acc;
   assign enq    = acc & ~direct;

   always_comb begin
      wr_en   = 1'b0;
      wr_addr = alu_addr;
      wr_data = alu_data;
      if (alu_we) begin
         wr_en = alu_hit;
      end else if (pop) begin
         wr_en   = ~head.dead & live(head.addr);
         wr_addr = head.addr;
         wr_data = head.data;
      end else if (direct) begin
         wr_en   = live(ld_addr);
         wr_addr = ld_addr;
         wr_data = ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hd  <= '0;
         tl  <= '0;
         cnt <= '0;
         for (int i = 0; i < QDEPTH; i++) q[i] <= '0;
      end else begin
         // A younger ALU write to the same register makes older queued loads dead.
         for (int i = 0; i < QDEPTH; i++)
            if (alu_hit && q[i].addr == alu_addr) q[i].dead <= 1'b1;
         if (enq) begin
            q[tl] <= {ld_addr, ld_data, alu_hit && (ld_addr == alu_addr)};
            tl    <= nxt(tl);
         end
         if (pop) hd <= nxt(hd);
         case ({enq, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   for (genvar i = 0; i < NREG; i++) begin : g_reg
      regbank_cell #(.WIDTH(WIDTH)) u_cell (
         .clk   (clk),
         .reset (reset),
         .we    (wr_en && (wr_addr == 6'(i))),
         .d     (wr_data),
         .q     (r[i])
      );
   end

   assign R00 = r[0];
   assign R01 = r[1];
   assign R02 = r[2];
   assign R03 = r[3];
   assign R04 = r[4];
   assign R05 = r[5];
   assign R06 = r[6];
   assign R07 = r[7];
   assign R08 = r[8];
   assign R09 = r[9];
   assign R10 = r[10];
   assign R11 = r[11];
   assign R12 = r[12];
   assign R13 = r[13];
   assign R14 = r[14];
   assign R15 = r[15];
   assign R16 = r[16];
   assign R17 = r[17];
   assign R18 = r[18];
   assign R19 = r[19];
   assign R20 = r[20];
   assign R21 = r[21];
   assign R22 = r[22];
   assign R23 = r[23];
   assign R24 = r[24];
   assign R25 = r[25];
   assign R26 = r[26];
   assign R27 = r[27];
   assign R28 = r[28];
   assign R29 = r[29];
   assign R30 = r[30];
   assign R31 = r[31];
   assign R32 = r[32];
   assign R33 = r[33];
   assign R34 = r[34];
   assign R35 = r[35];
   assign R36 = r[36];
   assign R37 = r[37];
   assign R38 = r[38];
   assign R39 = r[39];
   assign R40 = r[40];
   assign R41 = r[41];
   assign R42 = r[42];
   assign R43 = r[43];
   assign R44 = r[44];
   assign R45 = r[45];
   assign R46 = r[46];
   assign R47 = r[47];
   assign R48 = r[48];
   assign R49 = r[49];
   assign R50 = r[50];
   assign R51 = r[51];
   assign R52 = r[52];
   assign R53 = r[53];
   assign R54 = r[54];
   assign R55 = r[55];
   assign R56 = r[56];
   assign R57 = r[57];
   assign R58 = r[58];
   assign R59 = r[59];
   assign R60 = r[60];
   assign R61 = r[61];
endmodule
